// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: EX->MEM op bundle with valid/ready handshake.
// master drives the op fields and in_valid, slave returns in_ready.
interface mem_access_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;

  modport master (
    output in_valid, in_store, in_funct3,
    output in_addr, in_wdata, in_rd,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_store, in_funct3,
    input  in_addr, in_wdata, in_rd,
    output in_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32 MEM stage, loads/stores on word RAM, RMW for SB/SH.
// ports: clk, rst_n, up (op slave), ram_* (to ram_top), wb_* (RegFile), err.
module mem_access_unit #(
  parameter int RAM_AW = 16,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  up,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  output logic              ram_wen,
  input  logic [DW-1:0]     ram_rdata,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [DW-1:0]     wb_wdata,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RESP,
    S_MERGE,
    S_WR
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic        r_store;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;

  logic              w_acc;
  logic              w_bad;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [DW-1:0]     w_ram_wdata;
  logic              w_ram_wen;
  logic              w_wb_we;
  logic [4:0]        w_wb_waddr;
  logic [DW-1:0]     w_wb_wdata;
  logic              w_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld;
  logic [31:0]       w_mrg;

  assign up.in_ready = (r_state == S_IDLE);
  assign w_acc = up.in_valid && (r_state == S_IDLE);

  // funct3 100/101 exist only as loads (LBU/LHU)
  always_comb begin
    w_bad = 1'b0;
    case (up.in_funct3)
      3'b000: w_bad = 1'b0;
      3'b001: w_bad = up.in_addr[0];
      3'b010: w_bad = |up.in_addr[1:0];
      3'b100: w_bad = up.in_store;
      3'b101: w_bad = up.in_store | up.in_addr[0];
      default: w_bad = 1'b1;
    endcase
  end

  assign w_byte = 8'(ram_rdata >> {r_lane, 3'b000});
  assign w_half = r_lane[1] ? ram_rdata[31:16]
                            : ram_rdata[15:0];

  always_comb begin
    w_ld = ram_rdata;
    case (r_f3)
      3'b000: w_ld = {{24{w_byte[7]}}, w_byte};
      3'b001: w_ld = {{16{w_half[15]}}, w_half};
      3'b100: w_ld = {24'h0, w_byte};
      3'b101: w_ld = {16'h0, w_half};
      default: w_ld = ram_rdata;
    endcase
  end

  always_comb begin
    w_mrg = ram_rdata;
    if (r_f3[0])
      w_mrg[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
    else
      w_mrg[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
  end

  always_comb begin
    w_nxt       = r_state;
    w_ram_addr  = ram_addr;
    w_ram_wdata = ram_wdata;
    w_ram_wen   = 1'b0;
    w_wb_we     = 1'b0;
    w_wb_waddr  = wb_waddr;
    w_wb_wdata  = wb_wdata;
    w_err       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (up.in_valid) begin
          w_ram_addr = up.in_addr[RAM_AW+1:2];
          if (w_bad) begin
            w_err = 1'b1;
          end else if (up.in_store &&
                       up.in_funct3 == 3'b010) begin
            w_ram_wdata = up.in_wdata;
            w_ram_wen   = 1'b1;
            w_nxt       = S_WR;
          end else begin
            w_nxt = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        w_nxt = r_store ? S_MERGE : S_RESP;
      end
      S_RESP: begin
        w_wb_we    = (r_rd != 5'd0);
        w_wb_waddr = r_rd;
        w_wb_wdata = w_ld;
        w_nxt      = S_IDLE;
      end
      S_MERGE: begin
        w_ram_wdata = w_mrg;
        w_ram_wen   = 1'b1;
        w_nxt       = S_WR;
      end
      S_WR: begin
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wen   <= 1'b0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      wb_wdata  <= '0;
      err       <= 1'b0;
    end else begin
      ram_addr  <= w_ram_addr;
      ram_wdata <= w_ram_wdata;
      ram_wen   <= w_ram_wen;
      wb_we     <= w_wb_we;
      wb_waddr  <= w_wb_waddr;
      wb_wdata  <= w_wb_wdata;
      err       <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store <= 1'b0;
      r_f3    <= '0;
      r_lane  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (w_acc) begin
      r_store <= up.in_store;
      r_f3    <= up.in_funct3;
      r_lane  <= up.in_addr[1:0];
      r_wdata <= up.in_wdata;
      r_rd    <= up.in_rd;
    end
  end

endmodule
